// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, branch-mode and state definitions shared by the sequential ALU
package alu_pkg;

    localparam logic [5:0] OP_PASS = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_AND  = 6'h03;
    localparam logic [5:0] OP_OR   = 6'h04;
    localparam logic [5:0] OP_XOR  = 6'h05;
    localparam logic [5:0] OP_NOT  = 6'h06;
    localparam logic [5:0] OP_SHL  = 6'h07;
    localparam logic [5:0] OP_SHR  = 6'h08;
    localparam logic [5:0] OP_MUL  = 6'h09;
    localparam logic [5:0] OP_DIV  = 6'h0A;
    localparam logic [5:0] OP_MOD  = 6'h0B;

    localparam logic [1:0] ALUOP_BEQ_RES  = 2'b00;
    localparam logic [1:0] ALUOP_BEQ_IMM  = 2'b01;
    localparam logic [1:0] ALUOP_BNE_RES  = 2'b10;
    localparam logic [1:0] ALUOP_BEQ_IMM2 = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_iterative(input logic [5:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - WIDTH-step shift-add multiplier / restoring divider
module alu_muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    logic [WIDTH-1:0] hi_q, lo_q, b_q;
    logic             div_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH:0]   addend, sum, shifted;
    logic [WIDTH-1:0] sub, hi_nxt, lo_nxt;
    logic             ge;

    // hi_q is the partial product high half (mul) or running remainder (div);
    // lo_q is the multiplier being consumed or the dividend becoming the quotient.
    always_comb begin
        addend  = lo_q[0] ? {1'b0, b_q} : '0;
        sum     = {1'b0, hi_q} + addend;
        shifted = {hi_q, lo_q[WIDTH-1]};
        ge      = shifted >= {1'b0, b_q};
        sub     = shifted[WIDTH-1:0] - b_q;
        if (div_q) begin
            hi_nxt = ge ? sub : shifted[WIDTH-1:0];
            lo_nxt = {lo_q[WIDTH-2:0], ge};
        end else begin
            hi_nxt = sum[WIDTH:1];
            lo_nxt = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else if (start) begin
            hi_q  <= '0;
            lo_q  <= a;
            b_q   <= b;
            div_q <= is_div;
            cnt_q <= CNT_W'(WIDTH);
        end else if (cnt_q != '0) begin
            hi_q  <= hi_nxt;
            lo_q  <= lo_nxt;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Final step's result is handed out combinationally so the caller can register it on this edge.
    assign done        = (cnt_q == CNT_W'(1));
    assign hi          = hi_nxt;
    assign lo          = lo_nxt;
    assign div_by_zero = div_q && (b_q == '0);

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle handshaked ALU with iterative mul/div and branch-condition output
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [5:0]       operation,
    input  logic [1:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             div_by_zero
);

    state_t state_q, state_d;

    logic             accept, imm_mode, inv_zero, zero_calc, multi;
    logic [WIDTH-1:0] comb_res;

    logic [WIDTH-1:0] res_q, hi_q, d1_q;
    logic [5:0]       op_q;
    logic             zero_q, dbz_q;

    logic             md_done, md_dbz;
    logic [WIDTH-1:0] md_hi, md_lo;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;

    always_comb begin
        imm_mode = 1'b0;
        inv_zero = 1'b0;
        case (alu_op)
            ALUOP_BEQ_RES:  imm_mode = 1'b0;
            ALUOP_BEQ_IMM:  imm_mode = 1'b1;
            ALUOP_BNE_RES:  inv_zero = 1'b1;
            ALUOP_BEQ_IMM2: imm_mode = 1'b1;
            default:        imm_mode = 1'b0;
        endcase
    end

    assign zero_calc = (data1 == data2) ^ inv_zero;
    assign multi     = is_iterative(operation) && !imm_mode;

    // Shift operators already yield 0 for amounts >= WIDTH, matching the full-data2 rule.
    always_comb begin
        comb_res = '0;
        case (operation)
            OP_PASS: comb_res = data1;
            OP_ADD:  comb_res = data1 + data2;
            OP_SUB:  comb_res = data1 - data2;
            OP_AND:  comb_res = data1 & data2;
            OP_OR:   comb_res = data1 | data2;
            OP_XOR:  comb_res = data1 ^ data2;
            OP_NOT:  comb_res = ~data1;
            OP_SHL:  comb_res = data1 << data2;
            OP_SHR:  comb_res = data1 >> data2;
            default: comb_res = '0;
        endcase
    end

    alu_muldiv_iter #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_muldiv (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (accept && multi),
        .is_div     (operation != OP_MUL),
        .a          (data1),
        .b          (data2),
        .done       (md_done),
        .hi         (md_hi),
        .lo         (md_lo),
        .div_by_zero(md_dbz)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = multi ? BUSY : DONE;
            BUSY:    if (md_done) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= '0;
            hi_q   <= '0;
            d1_q   <= '0;
            op_q   <= '0;
            zero_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else if (accept) begin
            op_q   <= operation;
            d1_q   <= data1;
            zero_q <= zero_calc;
            dbz_q  <= 1'b0;
            hi_q   <= '0;
            res_q  <= imm_mode ? data2 : comb_res;
        end else if ((state_q == BUSY) && md_done) begin
            case (op_q)
                OP_MUL: begin
                    res_q <= md_lo;
                    hi_q  <= md_hi;
                end
                OP_DIV: begin
                    res_q <= md_dbz ? '1 : md_lo;
                    hi_q  <= md_dbz ? d1_q : md_hi;
                    dbz_q <= md_dbz;
                end
                OP_MOD: begin
                    res_q <= md_dbz ? d1_q : md_hi;
                    hi_q  <= md_dbz ? d1_q : md_hi;
                    dbz_q <= md_dbz;
                end
                default: begin
                end
            endcase
        end
    end

    assign alu_result  = res_q;
    assign result_hi   = hi_q;
    assign zero        = zero_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized scoreboard bench for alu_seq at WIDTH 32 plus WIDTH 8 corner cases
module tb_alu_seq;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic        zero;
        logic        dbz;
        int          lat;
        int          vcyc;
    } exp_t;

    logic        clk, rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, zero, div_by_zero;
    logic [31:0] data1, data2, alu_result, result_hi;
    logic [5:0]  operation;
    logic [1:0]  alu_op;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, zero8, dbz8;
    logic [7:0]  data1_8, data2_8, alu_result8, result_hi8;
    logic [5:0]  operation8;
    logic [1:0]  alu_op8;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   bp_mode  = 0;
    bit   seen     = 0;
    exp_t q[$];
    exp_t mon_e;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .data1(data1), .data2(data2), .operation(operation), .alu_op(alu_op),
        .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
        .result_hi(result_hi), .zero(zero), .div_by_zero(div_by_zero)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .data1(data1_8), .data2(data2_8), .operation(operation8), .alu_op(alu_op8),
        .out_valid(out_valid8), .out_ready(out_ready8), .alu_result(alu_result8),
        .result_hi(result_hi8), .zero(zero8), .div_by_zero(dbz8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (bp_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom % 10) < 7;
            default: out_ready = 1'b0;
        endcase
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic exp_t model(input logic [5:0] op, input logic [1:0] mode,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        e.res = 0; e.hi = 0; e.dbz = 0; e.lat = 1; e.vcyc = 0;
        e.zero = (a == b);
        if (mode == 2'b10) e.zero = !e.zero;
        if (mode == 2'b01 || mode == 2'b11) begin
            e.res = b;
            return e;
        end
        case (op)
            6'd0:  e.res = a;
            6'd1:  e.res = a + b;
            6'd2:  e.res = a - b;
            6'd3:  e.res = a & b;
            6'd4:  e.res = a | b;
            6'd5:  e.res = a ^ b;
            6'd6:  e.res = ~a;
            6'd7:  e.res = (b >= 32) ? 32'd0 : a << b[4:0];
            6'd8:  e.res = (b >= 32) ? 32'd0 : a >> b[4:0];
            6'd9: begin
                p = 64'(a) * 64'(b);
                e.res = p[31:0];
                e.hi  = p[63:32];
                e.lat = 33;
            end
            6'd10, 6'd11: begin
                e.lat = 33;
                if (b == 0) begin
                    e.res = (op == 6'd10) ? 32'hFFFF_FFFF : a;
                    e.hi  = a;
                    e.dbz = 1'b1;
                end else begin
                    e.res = (op == 6'd10) ? a / b : a % b;
                    e.hi  = a % b;
                end
            end
            default: e.res = 0;
        endcase
        return e;
    endfunction

    // Monitor: checks outputs every cycle they are presented, pops on handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 0;
        end else begin
            if (q.size() != 0) chk("in_ready_while_pending", in_ready, 0);
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: out_valid=1 with result 0x%0h and nothing pending (cycle %0d)", alu_result, cyc);
                end else begin
                    mon_e = q[0];
                    if (!seen) begin
                        chk("latency_cycle", cyc, mon_e.vcyc);
                        seen = 1;
                    end
                    chk("alu_result", alu_result, mon_e.res);
                    chk("result_hi", result_hi, mon_e.hi);
                    chk("zero", zero, mon_e.zero);
                    chk("div_by_zero", div_by_zero, mon_e.dbz);
                    if (out_ready) begin
                        void'(q.pop_front());
                        seen = 0;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [5:0] op, input logic [1:0] mode,
                         input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   n;
        e = model(op, mode, a, b);
        in_valid  = 1'b1;
        operation = op;
        alu_op    = mode;
        data1     = a;
        data2     = b;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL accept_timeout: in_ready stayed 0 for op 0x%0h", op);
            in_valid = 1'b0;
            return;
        end
        e.vcyc = cyc + e.lat;
        @(posedge clk);
        #1;
        q.push_back(e);
        in_valid = 1'b0;
        data1    = $urandom;
        data2    = $urandom;
        operation = 6'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d results still pending", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run8(input logic [5:0] op, input logic [1:0] mode, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] er, input logic [7:0] eh,
                        input logic edbz, input int elat);
        int acc, n;
        in_valid8  = 1'b1;
        operation8 = op;
        alu_op8    = mode;
        data1_8    = a;
        data2_8    = b;
        @(negedge clk);
        chk("w8_in_ready", in_ready8, 1);
        acc = cyc;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("w8_latency", cyc - acc, elat);
        chk("w8_alu_result", alu_result8, er);
        chk("w8_result_hi", result_hi8, eh);
        chk("w8_div_by_zero", dbz8, edbz);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom % 4)
            0:       return $urandom;
            1:       return 32'($urandom % 16);
            2:       return 32'hFFFF_FFFF - 32'($urandom % 4);
            default: return 32'd28 + 32'($urandom % 8);
        endcase
    endfunction

    initial begin
        logic [31:0] a, b;
        rst_n = 1'b0;
        in_valid = 1'b0; data1 = 0; data2 = 0; operation = 0; alu_op = 0;
        in_valid8 = 1'b0; data1_8 = 0; data2_8 = 0; operation8 = 0; alu_op8 = 0;
        out_ready = 1'b1; out_ready8 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_alu_result", alu_result, 0);
        chk("reset_result_hi", result_hi, 0);
        chk("reset_zero", zero, 0);
        chk("reset_div_by_zero", div_by_zero, 0);
        chk("reset_w8_out_valid", out_valid8, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(6'h01, 2'b00, 32'd7, 32'd5);
        issue(6'h09, 2'b00, 32'hFFFF_FFFF, 32'd2);
        issue(6'h0A, 2'b00, 32'd100, 32'd7);
        issue(6'h0B, 2'b00, 32'd100, 32'd7);
        issue(6'h0A, 2'b00, 32'd5, 32'd0);
        issue(6'h0B, 2'b00, 32'd5, 32'd0);
        issue(6'h02, 2'b10, 32'd9, 32'd9);
        issue(6'h09, 2'b01, 32'd0, 32'h1234);
        issue(6'h0A, 2'b11, 32'd6, 32'd0);
        issue(6'h07, 2'b00, 32'd1, 32'd31);
        issue(6'h07, 2'b00, 32'd1, 32'd32);
        issue(6'h08, 2'b00, 32'h8000_0000, 32'd40);
        issue(6'h06, 2'b00, 32'h0F0F_0000, 32'd0);
        issue(6'h3F, 2'b00, 32'd3, 32'd3);
        drain();

        bp_mode = 2;
        issue(6'h05, 2'b00, 32'hA5A5_A5A5, 32'h0FF0_0FF0);
        repeat (12) @(posedge clk);
        #1;
        bp_mode = 0;
        drain();

        issue(6'h0A, 2'b00, $urandom, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_alu_result", alu_result, 0);
        chk("abort_result_hi", result_hi, 0);
        chk("abort_zero", zero, 0);
        chk("abort_div_by_zero", div_by_zero, 0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_in_ready", in_ready, 1);
        repeat (40) @(posedge clk);
        #1;

        bp_mode = 1;
        for (int i = 0; i < 60; i++) begin
            a = rnd_val();
            b = rnd_val();
            if ($urandom % 6 == 0) b = a;
            if ($urandom % 8 == 0) b = 32'd0;
            issue(6'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), a, b);
        end
        drain();
        bp_mode = 0;

        run8(6'h01, 2'b00, 8'h80, 8'h80, 8'h00, 8'h00, 1'b0, 1);
        run8(6'h07, 2'b00, 8'h01, 8'd7, 8'h80, 8'h00, 1'b0, 1);
        run8(6'h07, 2'b00, 8'h01, 8'd8, 8'h00, 8'h00, 1'b0, 1);
        run8(6'h08, 2'b00, 8'h80, 8'd40, 8'h00, 8'h00, 1'b0, 1);
        run8(6'h09, 2'b00, 8'hFF, 8'h02, 8'hFE, 8'h01, 1'b0, 9);
        run8(6'h0A, 2'b00, 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 9);
        run8(6'h0B, 2'b00, 8'd20, 8'd6, 8'd2, 8'd2, 1'b0, 9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised multi-cycle successor to the single-cycle datapath ALU; sits between the register-read stage and the writeback/branch logic.
- Keeps the 6-bit operation encoding and the 2-bit ALUOp branch/immediate modes.
- Adds a valid/ready handshake, registered outputs, configurable width, iterative multiply/divide with a high-half/remainder result, and a divide-by-zero flag.

Parameters:
- WIDTH, 32, operand and result width; must be at least 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and operation present
- in_ready  out  1  block can accept an operation
- data1  in  WIDTH  operand A
- data2  in  WIDTH  operand B / immediate
- operation  in  6  opcode (encoding below)
- alu_op  in  2  mode: 00 BEQ/result, 01 BEQ/imm, 10 BNE/result, 11 BEQ/imm
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- alu_result  out  WIDTH  primary result
- result_hi  out  WIDTH  MUL high half, or DIV/MOD remainder; 0 otherwise
- zero  out  1  branch condition
- div_by_zero  out  1  DIV/MOD issued with data2 == 0

Behaviour:
- Opcodes:
  - 00 pass data1
  - 01 add
  - 02 sub
  - 03 and
  - 04 or
  - 05 xor
  - 06 not data1
  - 07 shl
  - 08 shr (logical)
  - 09 mul (unsigned)
  - 0A div (unsigned)
  - 0B mod (unsigned)
  - others: result 0
- Width rules:
  - add/sub wrap modulo 2^WIDTH.
  - Shifts use the full data2 value; a shift amount >= WIDTH gives 0.
- Mode rules:
  - zero = (data1 == data2), inverted when alu_op == 10.
  - alu_op 01/11: alu_result = data2, result_hi = 0. These complete in 1 cycle even when the opcode is mul/div/mod.
  - Otherwise alu_result is the computed result.
- Operands, opcode and mode are captured at acceptance (in_valid && in_ready). Inputs are don't-care afterwards.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready = 1. On acceptance, go to DONE for single-cycle ops, or to BUSY for mul/div/mod in result mode.
  - BUSY: one shift-add (mul) or restoring-subtract (div) step per cycle. The counter runs WIDTH cycles, then the FSM goes to DONE.
  - DONE: out_valid = 1, outputs stable. On out_ready, go to IDLE.
- Latency from acceptance cycle k:
  - single-cycle ops: out_valid at k+1.
  - mul/div/mod: out_valid at k+WIDTH+1.
- Throughput: one op in flight. in_ready is 0 in BUSY and DONE; it is not combinationally tied to out_ready.
- Divide by zero:
  - DIV: alu_result = all ones.
  - MOD: alu_result = data1.
  - DIV and MOD: result_hi = data1, div_by_zero = 1.
  - Still takes WIDTH+1 cycles, so timing does not depend on the data.
- div_by_zero is 0 for all other ops. It is valid only while out_valid is high.
- Reset (async assert, sync release): state IDLE, in_ready 1, out_valid 0, alu_result 0, result_hi 0, zero 0, div_by_zero 0, counter 0.
- Reset during BUSY or DONE aborts the op; no result is emitted.
- Backpressure: DONE holds all outputs unchanged for any number of cycles with out_ready = 0.
- in_valid while not ready is ignored. The source must hold its request until in_ready is high.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (OP_PASS ... OP_MOD)
  - alu_op localparams (ALUOP_BEQ_RES, ALUOP_BEQ_IMM, ALUOP_BNE_RES, ALUOP_BEQ_IMM2)
  - state enum
- One natural sub-module: alu_muldiv_iter, the WIDTH-cycle shift-add multiplier / restoring divider.
  - Start pulse, op select, done pulse.
  - Outputs {hi, lo} and div_by_zero.
- The single-cycle combinational ops stay in alu_seq.

Test Plan:
1. WIDTH=32; accept add 7+5, alu_op=00 -> out_valid one cycle later, alu_result=12, zero=0, result_hi=0.
2. mul 0xFFFFFFFF*0x2 -> out_valid 33 cycles after acceptance, alu_result=0xFFFFFFFE, result_hi=0x1; in_ready=0 throughout.
3. div 100/7 and mod 100/7 -> alu_result 14 / 2, result_hi 2 both; div 5/0 -> alu_result=0xFFFFFFFF, result_hi=5, div_by_zero=1 at cycle 33.
4. alu_op=10, data1=data2=9, sub -> zero=0, alu_result=0; alu_op=01, data2=0x1234, mul -> alu_result=0x1234 after 1 cycle, zero=0.
5. shl 1<<31 -> 0x80000000; shl 1<<32 -> 0; shr 0x80000000>>40 -> 0. Repeat at WIDTH=8: 0x80+0x80 -> 0x00.
6. Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0. Assert rst_n=0 mid-BUSY on a div -> all outputs 0 immediately, in_ready=1 after release, no result emitted.
